// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared SPI definitions: FSM state encoding, default word
//                width and the CKP/CPH edge-selection helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

   localparam int DATA_W_DEFAULT = 16;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   // Modes 0 and 3 (CKP==CPH) act on the rising SCK edge, modes 1 and 2 on
   // the falling edge. Swapping rise/fall gives the opposite edge.
   function automatic logic edge_sel(input logic ckp, input logic cph,
                                     input logic rise, input logic fall);
      return (ckp == cph) ? rise : fall;
   endfunction

endpackage
`default_nettype wire

// File: rtl/spi_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module      : spi_edge_detect
//  Description : Oversamples SCK in the clk domain and flags the sample and
//                shift edges for the selected CKP/CPH mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_edge_detect
   import spi_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic ckp_i,
   input  logic cph_i,
   input  logic sck_i,
   output logic sample_edge_o,
   output logic shift_edge_o
);

   logic sck_prev_q;
   logic w_rise;
   logic w_fall;

   // Previous SCK level; parks at the idle level so reset never fakes an edge.
   always_ff @(posedge clk) begin
      if (reset) sck_prev_q <= ckp_i;
      else       sck_prev_q <= sck_i;
   end

   assign w_rise        = sck_i & ~sck_prev_q;
   assign w_fall        = ~sck_i & sck_prev_q;
   assign sample_edge_o = edge_sel(ckp_i, cph_i, w_rise, w_fall);
   assign shift_edge_o  = edge_sel(ckp_i, cph_i, w_fall, w_rise);

endmodule
`default_nettype wire

// File: rtl/spi_subnode.sv
`default_nettype none
// ============================================================================
//  Module      : spi_subnode
//  Description : SPI subnode: deserialises MOSI into words with a valid/ack
//                handshake and serialises a locally loaded word onto MISO.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_subnode
   import spi_pkg::*;
#(
   parameter int                DATA_W   = DATA_W_DEFAULT,
   parameter logic [DATA_W-1:0] TX_RESET = '0
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              CKP,
   input  logic              CPH,
   input  logic              SCK,
   input  logic              CS,
   input  logic              MOSI,
   input  logic              reset_rec,
   output logic              MISO,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_load,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ack,
   output logic              overrun,
   output logic              frame_err
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   state_t            state_q;
   logic [CNT_W-1:0]  bit_cnt_q;
   logic [DATA_W-1:0] rx_shift_q;
   logic [DATA_W-1:0] tx_word_q;
   logic [DATA_W-1:0] tx_shift_q;
   logic [DATA_W-1:0] rx_data_q;
   logic              rx_valid_q;
   logic              overrun_q;
   logic              frame_err_q;
   logic              w_sample_edge;
   logic              w_shift_edge;
   logic [DATA_W-1:0] w_rx_next;

   spi_edge_detect u_edge (
      .clk           (clk),
      .reset         (reset),
      .ckp_i         (CKP),
      .cph_i         (CPH),
      .sck_i         (SCK),
      .sample_edge_o (w_sample_edge),
      .shift_edge_o  (w_shift_edge)
   );

   assign w_rx_next = {rx_shift_q[DATA_W-2:0], MOSI};

   // Frame FSM with receive/transmit shifters and handshake flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         rx_shift_q  <= '0;
         tx_word_q   <= TX_RESET;
         tx_shift_q  <= TX_RESET;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         if (tx_load) tx_word_q  <= tx_data;
         if (rx_ack)  rx_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               bit_cnt_q  <= '0;
               rx_shift_q <= '0;
               if (!CS) begin
                  state_q    <= ACTIVE;
                  tx_shift_q <= tx_word_q;
               end
            end
            ACTIVE: begin
               if (!reset_rec) begin
                  bit_cnt_q  <= '0;
                  rx_shift_q <= '0;
                  tx_shift_q <= tx_word_q;
                  if (CS) state_q <= IDLE;
               end else if (CS) begin
                  state_q    <= IDLE;
                  bit_cnt_q  <= '0;
                  rx_shift_q <= '0;
                  if (bit_cnt_q != '0) frame_err_q <= 1'b1;
               end else if (w_sample_edge) begin
                  rx_shift_q <= w_rx_next;
                  if (bit_cnt_q == LAST_BIT) begin
                     bit_cnt_q  <= '0;
                     rx_data_q  <= w_rx_next;
                     rx_valid_q <= 1'b1;
                     tx_shift_q <= tx_word_q;
                     if (rx_valid_q && !rx_ack) overrun_q <= 1'b1;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
               end else if (w_shift_edge && bit_cnt_q != '0) begin
                  // A shift edge seen at a word boundary (CPH=1 leading edge
                  // or CPH=0 trailing edge of the last bit) must not consume
                  // the freshly loaded MSB.
                  tx_shift_q <= tx_shift_q << 1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign MISO      = (state_q == ACTIVE && !CS) ? tx_shift_q[DATA_W-1] : 1'b0;
   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign overrun   = overrun_q;
   assign frame_err = frame_err_q;

endmodule
`default_nettype wire
